// File: rtl/lu_pipe_seq.sv
// LU-decomposition pipeline sequencer: walks the k/j/i iteration space for one
// of four compute modes and emits per-triple control strobes to the datapath.
module lu_pipe_seq #(
  parameter  int IS_BPU       = 1,
  parameter  int N            = 32,
  parameter  int RECIP_CYCLES = 4,
  localparam int CW           = $clog2(N)
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_go,
  input  logic [1:0]    i_mode,
  input  logic          i_flush,
  input  logic          i_whichpage,
  input  logic          i_stall,
  input  logic          i_pipe_empty,
  output logic          o_done,
  output logic          o_err,
  output logic          o_busy,
  output logic          o_valid,
  output logic          o_norm,
  output logic          o_recip,
  output logic          o_wr_top,
  output logic          o_wr_left,
  output logic          o_wr_cur,
  output logic          o_whichpage,
  output logic [CW-1:0] o_k,
  output logic [CW-1:0] o_i,
  output logic [CW-1:0] o_j
);

  // t_cpu_comp_mode encoding
  localparam logic [1:0] MODE_1 = 2'd0;
  localparam logic [1:0] MODE_2 = 2'd1;
  localparam logic [1:0] MODE_3 = 2'd2;
  localparam logic [1:0] MODE_4 = 2'd3;

  localparam int            RCW   = $clog2(RECIP_CYCLES + 1);
  localparam logic [CW-1:0] LAST  = CW'(N - 1);
  localparam logic [RCW-1:0] RLAST = RCW'(RECIP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RECIP, S_WRECIP, S_NORM, S_WNORM, S_UPD, S_WUPD, S_DONE
  } state_t;

  state_t         state, nstate;
  logic [CW-1:0]  k, i, j, nk, ni, nj;
  logic [RCW-1:0] rc, nrc;
  logic [1:0]     mode;
  logic           flush, whichpage, err;
  logic           mode_ok, accept, issue;
  logic [CW-1:0]  i_restart;

  function automatic logic [CW-1:0] inc(input logic [CW-1:0] x);
    return (x == LAST) ? '0 : x + 1'b1;
  endfunction

  assign mode_ok = (IS_BPU != 0) || (i_mode == MODE_3) || (i_mode == MODE_4);
  assign accept  = (state == S_IDLE) && i_go && mode_ok;
  // MODE_2 sweeps full columns; MODE_1/MODE_3 restart the inner loop below the pivot
  assign i_restart = (mode == MODE_2) ? '0 : inc(k);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      k         <= '0;
      i         <= '0;
      j         <= '0;
      rc        <= '0;
      mode      <= MODE_1;
      flush     <= 1'b0;
      whichpage <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= nstate;
      k     <= nk;
      i     <= ni;
      j     <= nj;
      rc    <= nrc;
      err   <= (state == S_IDLE) && i_go && !mode_ok;
      if (accept) begin
        mode      <= i_mode;
        flush     <= i_flush;
        whichpage <= i_whichpage;
      end
    end
  end

  always_comb begin
    nstate = state;
    nk     = k;
    ni     = i;
    nj     = j;
    nrc    = rc;
    case (state)
      S_IDLE: begin
        if (accept) begin
          nk  = '0;
          nj  = '0;
          ni  = '0;
          nrc = '0;
          case (i_mode)
            MODE_1:  nstate = S_RECIP;
            MODE_2:  nstate = S_NORM;
            MODE_3: begin
              nstate = S_UPD;
              ni     = inc('0);
            end
            default: nstate = S_UPD;
          endcase
        end
      end
      S_RECIP: begin
        if (!i_stall) begin
          if (rc == RLAST) begin
            nrc    = '0;
            nstate = S_WRECIP;
          end else begin
            nrc = rc + 1'b1;
          end
        end
      end
      S_WRECIP: begin
        if (i_pipe_empty) begin
          if (k == LAST) begin
            nstate = S_DONE;
          end else begin
            nstate = S_NORM;
            ni     = inc(k);
            nj     = k;
          end
        end
      end
      S_NORM: begin
        if (!i_stall) begin
          if (i == LAST) nstate = S_WNORM;
          else           ni     = inc(i);
        end
      end
      S_WNORM: begin
        if (i_pipe_empty) begin
          if (mode == MODE_2 && k == LAST) begin
            nstate = S_DONE;
          end else begin
            nstate = S_UPD;
            nj     = inc(k);
            ni     = (mode == MODE_2) ? '0 : inc(k);
          end
        end
      end
      S_UPD: begin
        if (!i_stall) begin
          if (mode == MODE_4) begin
            // dense k/j/i sweep, no drain between k steps
            ni = inc(i);
            if (i == LAST) begin
              nj = inc(j);
              if (j == LAST) begin
                nk = inc(k);
                if (k == LAST) nstate = S_DONE;
              end
            end
          end else if (i == LAST) begin
            if (j == LAST) begin
              nstate = S_WUPD;
            end else begin
              nj = inc(j);
              ni = i_restart;
            end
          end else begin
            ni = inc(i);
          end
        end
      end
      S_WUPD: begin
        if (i_pipe_empty) begin
          nk = inc(k);
          case (mode)
            MODE_1: begin
              nstate = S_RECIP;
              ni     = inc(k);
              nj     = inc(k);
              nrc    = '0;
            end
            MODE_2: begin
              nstate = S_NORM;
              nj     = inc(k);
              ni     = '0;
            end
            default: begin
              if (inc(k) == LAST) begin
                nstate = S_DONE;
              end else begin
                nstate = S_UPD;
                nj     = '0;
                ni     = inc(inc(k));
              end
            end
          endcase
        end
      end
      S_DONE: begin
        if (!flush || i_pipe_empty) nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    issue = !i_stall && ((state == S_NORM) || (state == S_UPD) ||
                         ((state == S_RECIP) && (rc == RLAST)));
    o_valid     = issue;
    o_busy      = (state != S_IDLE);
    o_recip     = (state == S_RECIP);
    o_norm      = (state == S_NORM);
    o_done      = (state == S_DONE) && (!flush || i_pipe_empty);
    o_err       = err;
    o_whichpage = whichpage;
    o_k         = k;
    o_i         = i;
    o_j         = j;
    o_wr_top    = 1'b0;
    o_wr_left   = 1'b0;
    o_wr_cur    = 1'b0;
    // reciprocal issues carry no matrix writes
    if (issue && (state != S_RECIP)) begin
      o_wr_cur = 1'b1;
      case (mode)
        MODE_1: begin
          o_wr_top  = 1'b1;
          o_wr_left = 1'b1;
        end
        MODE_2:  o_wr_left = 1'b1;
        MODE_3:  o_wr_top  = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lu_pipe_seq.sv
// Scoreboard bench for lu_pipe_seq at N=4: expected triples are queued at
// issue time and a negedge monitor compares every o_valid beat in order.
module tb_lu_pipe_seq;
  localparam int N  = 4;
  localparam int CW = 2;
  localparam logic [1:0] M1 = 2'd0, M2 = 2'd1, M3 = 2'd2, M4 = 2'd3;

  logic clk = 0, reset = 1;
  logic go = 0, go_nb = 0, flush = 0, wp = 0, stall, pempty = 1;
  logic [1:0] mode = M4, mode_nb = M1;
  logic done, err, busy, valid, norm, recip, wtop, wleft, wcur, owp;
  logic [CW-1:0] ok, oi, oj;
  logic nb_done, nb_err, nb_busy, nb_valid, nb_norm, nb_recip, nb_wtop, nb_wleft, nb_wcur, nb_wp;
  logic [CW-1:0] nb_k, nb_i, nb_j;

  int errors = 0, checks = 0, nvalid = 0, cyc = 0, last_vcyc = 0, done_cyc = 0, rrun = 0;
  bit rand_stall = 0, chk_recip = 0;
  logic [10:0] sb[$];

  always #5 clk = ~clk;

  lu_pipe_seq #(.IS_BPU(1), .N(N), .RECIP_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .i_go(go), .i_mode(mode), .i_flush(flush),
    .i_whichpage(wp), .i_stall(stall), .i_pipe_empty(pempty),
    .o_done(done), .o_err(err), .o_busy(busy), .o_valid(valid), .o_norm(norm),
    .o_recip(recip), .o_wr_top(wtop), .o_wr_left(wleft), .o_wr_cur(wcur),
    .o_whichpage(owp), .o_k(ok), .o_i(oi), .o_j(oj));

  lu_pipe_seq #(.IS_BPU(0), .N(N), .RECIP_CYCLES(4)) dut_nb (
    .clk(clk), .reset(reset), .i_go(go_nb), .i_mode(mode_nb), .i_flush(flush),
    .i_whichpage(wp), .i_stall(stall), .i_pipe_empty(pempty),
    .o_done(nb_done), .o_err(nb_err), .o_busy(nb_busy), .o_valid(nb_valid), .o_norm(nb_norm),
    .o_recip(nb_recip), .o_wr_top(nb_wtop), .o_wr_left(nb_wleft), .o_wr_cur(nb_wcur),
    .o_whichpage(nb_wp), .o_k(nb_k), .o_i(nb_i), .o_j(nb_j));

  task automatic check(input bit ok_c, input string name, input int act, input int exp);
    checks++;
    if (!ok_c) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {k,j,i,recip,norm,top,left,cur}
  function automatic logic [10:0] ev(input int k, j, i, input bit r, n, t, l, c);
    logic [1:0] kk, jj, ii;
    kk = k[1:0]; jj = j[1:0]; ii = i[1:0];
    return {kk, jj, ii, r, n, t, l, c};
  endfunction

  always @(posedge clk) begin
    #1 stall = rand_stall ? ($urandom_range(0, 99) < 30) : 1'b0;
  end

  always @(negedge clk) begin
    logic [10:0] act, exp;
    cyc++;
    if (!reset) begin
      if (valid) begin
        nvalid++;
        last_vcyc = cyc;
        act = {ok, oj, oi, recip, norm, wtop, wleft, wcur};
        if (sb.size() == 0) check(0, "sb_extra_valid", int'(act), 0);
        else begin
          exp = sb.pop_front();
          check(act == exp, "sb_triple", int'(act), int'(exp));
        end
      end
      if (done) done_cyc = cyc;
      if (chk_recip) begin
        if (recip) rrun++;
        else if (rrun != 0) begin
          check(rrun == 4, "recip_len", rrun, 4);
          rrun = 0;
        end
      end
    end
  end

  task automatic push_model(input logic [1:0] m);
    case (m)
      M1: for (int k = 0; k < N; k++) begin
        sb.push_back(ev(k, k, k, 1, 0, 0, 0, 0));
        if (k == N-1) break;
        for (int i = k+1; i < N; i++) sb.push_back(ev(k, k, i, 0, 1, 1, 1, 1));
        for (int j = k+1; j < N; j++)
          for (int i = k+1; i < N; i++) sb.push_back(ev(k, j, i, 0, 0, 1, 1, 1));
      end
      M2: for (int k = 0; k < N; k++) begin
        for (int i = 0; i < N; i++) sb.push_back(ev(k, k, i, 0, 1, 0, 1, 1));
        if (k == N-1) break;
        for (int j = k+1; j < N; j++)
          for (int i = 0; i < N; i++) sb.push_back(ev(k, j, i, 0, 0, 0, 1, 1));
      end
      M3: for (int k = 0; k < N-1; k++)
        for (int j = 0; j < N; j++)
          for (int i = k+1; i < N; i++) sb.push_back(ev(k, j, i, 0, 0, 1, 0, 1));
      default: for (int k = 0; k < N; k++)
        for (int j = 0; j < N; j++)
          for (int i = 0; i < N; i++) sb.push_back(ev(k, j, i, 0, 0, 0, 0, 1));
    endcase
  endtask

  task automatic start(input logic [1:0] m, input bit fl, input bit page);
    push_model(m);
    @(posedge clk); #1;
    go = 1; mode = m; flush = fl; wp = page;
    @(posedge clk); #1;
    go = 0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check(seen, name, 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [1:0] m, input int exp_cnt, input string name);
    nvalid = 0;
    start(m, 0, 0);
    wait_done(name);
    check(nvalid == exp_cnt, "valid_count", nvalid, exp_cnt);
    check(sb.size() == 0, "sb_leftover", sb.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check({done, err, busy, valid, norm, recip, wtop, wleft, wcur, owp, ok, oi, oj} == '0,
          "reset_outputs", int'({busy, valid, ok, oi, oj}), 0);
    @(posedge clk); #1 reset = 0;

    // dense sweep, done one cycle after last valid
    run(M4, 64, "m4_done");
    check(done_cyc - last_vcyc == 1, "m4_done_lat", done_cyc - last_vcyc, 1);
    run(M3, 24, "m3_done");
    chk_recip = 1;
    run(M1, 24, "m1_done");
    chk_recip = 0; rrun = 0;
    run(M2, 40, "m2_done");

    // backpressure: ordering enforced by scoreboard, count unchanged
    rand_stall = 1;
    run(M4, 64, "m4_stall_done");
    run(M1, 24, "m1_stall_done");
    rand_stall = 0;

    // IS_BPU=0 rejects MODE_1
    @(posedge clk); #1 go_nb = 1; mode_nb = M1;
    @(posedge clk); #1 go_nb = 0;
    @(negedge clk);
    check(nb_err == 1 && nb_busy == 0, "nb_err_pulse", int'({nb_err, nb_busy}), 2);
    @(negedge clk);
    check(nb_err == 0 && nb_busy == 0, "nb_err_clear", int'({nb_err, nb_busy}), 0);

    // flush holds DONE until the datapath drains
    pempty = 0; nvalid = 0;
    start(M4, 1, 1);
    for (int c = 0; c < 500 && sb.size() != 0; c++) @(negedge clk);
    check(sb.size() == 0 && nvalid == 64, "flush_valids", nvalid, 64);
    check(owp == 1, "whichpage", owp, 1);
    begin
      int early = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (done || !busy) early++;
      end
      check(early == 0, "flush_hold", early, 0);
    end
    @(posedge clk); #1 pempty = 1;
    @(negedge clk);
    check(done == 1, "flush_done", done, 1);
    @(negedge clk);
    check(busy == 0, "flush_idle", busy, 0);

    // reset mid-operation
    start(M4, 0, 1);
    repeat (20) @(posedge clk);
    #1 reset = 1;
    sb.delete();
    @(negedge clk);
    check({done, busy, valid, owp, ok, oi, oj} == '0, "rst_mid_out", int'({busy, valid, owp}), 0);
    @(posedge clk); #1 reset = 0;
    begin
      int bad = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if ({done, busy, valid, owp, ok, oi, oj} != '0) bad++;
      end
      check(bad == 0, "rst_mid_quiet", bad, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lu_pipe_seq.md
LU_PIPE_SEQ -- requirements
Module: lu_pipe_seq

Interface
REQ-001 SHALL have parameter IS_BPU, default 1: when 1, MODE_1 and MODE_2 are supported.
REQ-002 SHALL have parameter N, default 32: block dimension in rows/cols, range 2..256.
REQ-003 SHALL have parameter RECIP_CYCLES, default 4: reciprocal latency in cycles, range 1..16.
REQ-004 SHALL define CW = $clog2(N).
REQ-005 SHALL have port clk, input, 1: sole clock.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port i_go, input, 1: start pulse, sampled in IDLE only.
REQ-008 SHALL have port i_mode, input, 2: t_cpu_comp_mode (MODE_1..MODE_4).
REQ-009 SHALL have ports i_flush and i_whichpage, input, 1 each: captured on an accepted i_go.
REQ-010 SHALL have port i_stall, input, 1: downstream backpressure.
REQ-011 SHALL have port i_pipe_empty, input, 1: datapath drained.
REQ-012 SHALL have ports o_done, o_err, output, 1 each: single-cycle pulses.
REQ-013 SHALL have port o_busy, output, 1: high whenever state is not IDLE.
REQ-014 SHALL have ports o_valid, o_norm, o_recip, o_wr_top, o_wr_left, o_wr_cur, o_whichpage, output, 1 each: pipeline control.
REQ-015 SHALL have ports o_k, o_i, o_j, output, CW each: internal loop indices.

Function
REQ-016 SHALL hold k/i/j counters internally; no external counter handshake.
REQ-017 SHALL define *done flags as idx==N-1 and SHALL wrap increments modulo N.
REQ-018 SHALL, on i_go in IDLE, capture flush and whichpage, zero k/i/j, and enter the mode's first state.
REQ-019 SHALL, on i_go in IDLE with MODE_1 or MODE_2 while IS_BPU=0, pulse o_err for 1 cycle and stay IDLE.
REQ-020 SHALL ignore i_go outside IDLE.
REQ-021 SHALL implement MODE_1 (per k):
- RECIP: o_recip=1 for RECIP_CYCLES cycles; o_valid=1 on the last cycle only.
- Wait for i_pipe_empty.
- If k==N-1, go to DONE.
- Else NORM: i=k+1..N-1, j=k, o_norm; writes top/left/cur.
- Wait for i_pipe_empty.
- UPDATE: j=k+1..N-1 outer, i=k+1..N-1 inner; writes top/left/cur.
- Wait for i_pipe_empty; k++.
REQ-022 SHALL implement MODE_2 (per k):
- NORM: j=k, i=0..N-1; writes left/cur.
- Wait for i_pipe_empty.
- If k==N-1, go to DONE.
- Else UPDATE: j=k+1..N-1, i=0..N-1; writes left/cur.
- Wait for i_pipe_empty; k++.
REQ-023 SHALL implement MODE_3 (per k):
- If k==N-1, go to DONE.
- Else UPDATE: j=0..N-1, i=k+1..N-1; writes top/cur.
- Wait for i_pipe_empty; k++.
REQ-024 SHALL implement MODE_4: k, j, i all 0..N-1, writes cur, with no gap cycles between iterations; after k=j=i=N-1, go to DONE.
REQ-025 SHALL assert o_valid exactly once per issued (k,j,i) triple, with o_k/o_i/o_j and the mode strobes valid in that same cycle.
REQ-026 SHALL, while i_stall=1 in an issuing state, drive o_valid=0 and hold all counters, recip count and state; o_norm and o_recip keep their state values.
REQ-027 SHALL treat i_stall as a don't-care in wait states and in DONE.
REQ-028 SHALL, in DONE, pulse o_done and return to IDLE once (!flush || i_pipe_empty); otherwise remain in DONE.
REQ-029 SHALL drive o_whichpage from the captured register at all times.
REQ-030 SHALL, when the RECIP end and i_stall coincide, drive o_valid=0 and extend RECIP until i_stall deasserts.

Reset
REQ-031 SHALL, on reset, set state to IDLE, zero k/i/j and the recip count, and clear flush/whichpage.
REQ-032 SHALL drive every output to 0 during and immediately after reset.
REQ-033 SHALL, when reset asserts mid-operation, abort without emitting o_done.

Verification
REQ-034 SHALL cover N=4, MODE_4, no stall -> 64 consecutive o_valid; o_done one cycle after the last valid (flush=0).
REQ-035 SHALL cover N=4, MODE_3 -> 24 valids; first triple (k0,j0,i1); o_wr_top=o_wr_cur=1; o_wr_left=0.
REQ-036 SHALL cover N=4, RECIP_CYCLES=4, MODE_1, i_pipe_empty=1 -> 24 valids (4 recip + 6 norm + 14 update); o_recip held for 4 cycles each k.
REQ-037 SHALL cover N=4, MODE_2 -> 40 valids (16 norm + 24 update).
REQ-038 SHALL cover MODE_4 with random i_stall at 30% -> valid count still 64; indices never skip or repeat.
REQ-039 SHALL cover: IS_BPU=0 with MODE_1 -> o_err pulse, o_busy stays 0; flush=1 with i_pipe_empty held 0 for 10 cycles -> o_done delayed until empty; reset mid-MODE_4 -> outputs 0, no o_done.
